vram_dma: RTL

- Bus initiator that copies a block of bytes from a CPU-side shadow RAM into GPU VRAM.
- Drives the GPU's VRAM write port (data, address, write enable, VRAM select, clear-vblank-IRQ select). Writes only while the GPU reports the writable (vblank) window.
- Sits beside the CPU bus arbiter, so the CPU can queue a full tile or sprite update and have it land in VRAM without tearing.

---
 rtl/vram_dma.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vram_dma.sv
// Block copier from CPU shadow RAM into GPU VRAM. Writes happen only inside the GPU
// vblank window, and the copy resumes at the first unwritten byte after a window closes.
module vram_dma #(
  parameter int VRAM_AW = 14,
  parameter int SRC_AW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SRC_AW-1:0]  src_base,
  input  logic [VRAM_AW-1:0] dst_base,
  input  logic [VRAM_AW:0]   length,
  output logic               busy,
  output logic               done,
  output logic [SRC_AW-1:0]  src_addr,
  output logic               src_rd,
  input  logic [7:0]         src_data,
  input  logic               in_vblank,
  input  logic               vblank_irq,
  output logic [7:0]         vram_data,
  output logic [VRAM_AW-1:0] vram_address,
  output logic               vram_we,
  output logic               vram_select,
  output logic               clr_irq_select,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACK    = 3'd2,
    S_STREAM = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [VRAM_AW:0] CNT_ONE = {{VRAM_AW{1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [SRC_AW-1:0]  src_q;
  logic [VRAM_AW-1:0] dst_q;
  logic [VRAM_AW:0]   len_q;
  logic [VRAM_AW:0]   rd_idx;
  logic [VRAM_AW:0]   wr_idx;
  logic [VRAM_AW:0]   remaining;
  logic               wr_valid;
  logic               rd_ok;
  logic               rd_fire;
  logic               wr_fire;

  assign rd_ok     = (rd_idx != len_q);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Every write strobe is qualified by the live in_vblank level, so a window that
  // closes mid-cycle never lets a write escape.
  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    src_rd         = 1'b0;
    vram_we        = 1'b0;
    vram_select    = 1'b0;
    clr_irq_select = 1'b0;
    rd_fire        = 1'b0;
    wr_fire        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (length == '0) ? S_FINISH : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (in_vblank) state_nxt = vblank_irq ? S_ACK : S_STREAM;
      end
      S_ACK: begin
        busy           = 1'b1;
        clr_irq_select = 1'b1;
        vram_we        = in_vblank;
        state_nxt      = in_vblank ? S_STREAM : S_WAIT;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (!in_vblank) begin
          state_nxt = S_WAIT;
        end else begin
          rd_fire     = rd_ok;
          src_rd      = rd_ok;
          wr_fire     = wr_valid;
          vram_we     = wr_valid;
          vram_select = wr_valid;
          if (wr_valid && remaining == CNT_ONE) state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/data buses are held at zero whenever the matching strobe is low.
  assign src_addr     = rd_fire ? (src_q + SRC_AW'(rd_idx)) : '0;
  assign vram_address = wr_fire ? (dst_q + VRAM_AW'(wr_idx)) : '0;
  assign vram_data    = wr_fire ? src_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      remaining <= '0;
      wr_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wr_valid <= 1'b0;
          if (start && length != '0) begin
            src_q     <= src_base;
            dst_q     <= dst_base;
            len_q     <= length;
            remaining <= length;
            rd_idx    <= '0;
            wr_idx    <= '0;
          end
        end
        S_STREAM: begin
          if (!in_vblank) begin
            // Drop the byte in flight; it is re-read when the next window opens.
            rd_idx   <= wr_idx;
            wr_valid <= 1'b0;
          end else begin
            wr_valid <= rd_fire;
            if (rd_fire) rd_idx <= rd_idx + CNT_ONE;
            if (wr_fire) begin
              wr_idx    <= wr_idx + CNT_ONE;
              remaining <= remaining - CNT_ONE;
            end
          end
        end
        default: wr_valid <= 1'b0;
      endcase
    end
  end

  a_sel_excl: assert property (@(posedge clk) disable iff (!rst)
    !(vram_select && clr_irq_select));
  a_we_vblank: assert property (@(posedge clk) disable iff (!rst)
    vram_we |-> in_vblank);

endmodule
